// File: rtl/regfile_dump.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_dump: stalls the CPU and streams (index, data) beats read through |
// | the register file's readReg1 port.                  Revision: 1.0        |
// +--------------------------------------------------------------------------+
module regfile_dump #(
  parameter int DATAWIDTH = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [4:0]           readReg,
  input  logic [DATAWIDTH-1:0] readData,
  output logic                 cpu_stall,
  output logic                 busy,
  output logic                 done,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [4:0]           dump_index,
  output logic [DATAWIDTH-1:0] dump_data
);

  localparam logic [4:0] c_first_idx = 5'(FIRST_REG);
  localparam logic [4:0] c_last_idx  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [4:0]             idx_q, idx_d;
  logic                   dump_valid_q, dump_valid_d;
  logic [4:0]             dump_index_q, dump_index_d;
  logic [DATAWIDTH-1:0]   dump_data_q, dump_data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_index_q <= '0;
      dump_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dump_valid_q <= dump_valid_d;
      dump_index_q <= dump_index_d;
      dump_data_q  <= dump_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dump_valid_d = dump_valid_q;
    dump_index_d = dump_index_q;
    dump_data_d  = dump_data_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          idx_d   = c_first_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        // readData is registered in the register file, so it reflects idx now
        dump_data_d  = readData;
        dump_index_d = idx_q;
        dump_valid_d = 1'b1;
        state_d      = S_SEND;
      end
      S_SEND: begin
        if (dump_valid_q && dump_ready) begin
          dump_valid_d = 1'b0;
          if (idx_q == c_last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
    end

    // Every output reads as zero while idle, so clear the datapath on entry
    if (state_d == S_IDLE) begin
      idx_d        = '0;
      dump_valid_d = 1'b0;
      dump_index_d = '0;
      dump_data_d  = '0;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign cpu_stall  = busy;
  assign done       = (state_q == S_DONE);
  assign readReg    = busy ? idx_q : 5'd0;
  assign dump_valid = dump_valid_q;
  assign dump_index = dump_index_q;
  assign dump_data  = dump_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_dump: checks full-range and narrow-range dump engines against  |
// | a registered register-file model.                   Revision: 1.0        |
// +--------------------------------------------------------------------------+
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, abort_a, ready_a;
  logic        start_b, abort_b, ready_b;
  logic [4:0]  rr_a, rr_b, idx_a, idx_b;
  logic [31:0] rd_a, rd_b, data_a, data_b;
  logic        stall_a, busy_a, done_a, valid_a;
  logic        stall_b, busy_b, done_b, valid_b;

  logic [31:0] regs [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Register file read port: readData1 is registered from readReg1
  always @(posedge clk) begin
    rd_a <= regs[rr_a];
    rd_b <= regs[rr_b];
  end

  regfile_dump #(.DATAWIDTH(32), .FIRST_REG(0), .LAST_REG(31)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .readReg(rr_a), .readData(rd_a), .cpu_stall(stall_a), .busy(busy_a),
    .done(done_a), .dump_valid(valid_a), .dump_ready(ready_a),
    .dump_index(idx_a), .dump_data(data_a)
  );

  regfile_dump #(.DATAWIDTH(32), .FIRST_REG(5), .LAST_REG(7)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .readReg(rr_b), .readData(rd_b), .cpu_stall(stall_b), .busy(busy_b),
    .done(done_b), .dump_valid(valid_b), .dump_ready(ready_b),
    .dump_index(idx_b), .dump_data(data_b)
  );

  typedef struct {
    logic       st;
    logic       ab;
    logic       e_busy;
    logic       e_done;
    logic       e_valid;
    logic [4:0] e_rr;
    logic [4:0] e_idx;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [31:0] exp_data(input int n);
    return (n == 0) ? 32'h0 : 32'hA5A50000 + 32'(n);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".busy"},  64'(busy_a),  64'd0);
    chk({tag, ".stall"}, 64'(stall_a), 64'd0);
    chk({tag, ".done"},  64'(done_a),  64'd0);
    chk({tag, ".valid"}, 64'(valid_a), 64'd0);
    chk({tag, ".rr"},    64'(rr_a),    64'd0);
    chk({tag, ".idx"},   64'(idx_a),   64'd0);
    chk({tag, ".data"},  64'(data_a),  64'd0);
  endtask

  // One dump on instance A starting from IDLE. bp selects the 0,0,1 sink.
  task automatic dump_a(input bit bp, input bit busy_starts, input bit tail_start);
    int exp_done, beat, hold;
    bit p_stall;
    logic [4:0]  p_idx;
    logic [31:0] p_data;
    exp_done = bp ? 161 : 97;
    beat = 0; hold = 0; p_stall = 0; p_idx = '0; p_data = '0;
    @(negedge clk);
    start_a = 1'b1; abort_a = 1'b0; ready_a = !bp;
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      start_a = (busy_starts && (c == 10 || c == 50)) ||
                (tail_start && (c == exp_done || c == exp_done + 1));
      if (c == exp_done + 1) begin
        chk_idle_a("a.end");
      end else begin
        chk("a.busy",  64'(busy_a),  64'd1);
        chk("a.stall", 64'(stall_a), 64'd1);
        chk("a.done",  64'(done_a),  64'(c == exp_done));
        chk("a.valid", 64'(valid_a),
            64'(bp ? (((c - 1) % 5) >= 2 && c < exp_done) : (c % 3 == 0 && c < exp_done)));
        chk("a.rr",    64'(rr_a),    64'((beat > 31) ? 31 : beat));
        if (p_stall && valid_a) begin
          chk("a.hold_idx",  64'(idx_a),  64'(p_idx));
          chk("a.hold_data", 64'(data_a), 64'(p_data));
        end
        if (bp) begin
          if (valid_a) hold++;
          ready_a = valid_a && (hold == 3);
        end else begin
          ready_a = 1'b1;
        end
        if (valid_a && ready_a) begin
          chk("a.beat_idx",  64'(idx_a),  64'(beat));
          chk("a.beat_data", 64'(data_a), 64'(exp_data(beat)));
          beat++;
          hold = 0;
        end
        p_stall = valid_a && !ready_a;
        p_idx   = idx_a;
        p_data  = data_a;
      end
    end
    chk("a.beats", 64'(beat), 64'd32);
    if (tail_start) begin
      // start in DONE was ignored; start in the first IDLE cycle is taken
      @(negedge clk);
      start_a = 1'b0;
      chk("a.restart_busy", 64'(busy_a), 64'd1);
      chk("a.restart_rr",   64'(rr_a),   64'd0);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      chk("a.restart_abort", 64'(busy_a), 64'd0);
    end else begin
      start_a = 1'b0;
    end
    ready_a = 1'b1;
  endtask

  task automatic kill_run(input bit use_reset);
    bit found;
    found = 0;
    @(negedge clk);
    start_a = 1'b1; ready_a = 1'b1;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (valid_a && idx_a == 5'd7) begin
        found = 1;
        ready_a = 1'b0;
        if (use_reset) reset = 1'b1; else abort_a = 1'b1;
      end
    end
    chk("kill.found_idx7", 64'(found), 64'd1);
    @(negedge clk);
    reset = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
    chk("kill.valid", 64'(valid_a), 64'd0);
    chk("kill.stall", 64'(stall_a), 64'd0);
    chk("kill.busy",  64'(busy_a),  64'd0);
    chk("kill.done",  64'(done_a),  64'd0);
    if (use_reset) begin
      chk("kill.idx",  64'(idx_a),  64'd0);
      chk("kill.data", 64'(data_a), 64'd0);
    end
    @(negedge clk);
    chk("kill.done_after", 64'(done_a), 64'd0);
    chk("kill.busy_after", 64'(busy_a), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i);

    //            st    ab    busy  done  valid rr     idx
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 5'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 5'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 5'd6};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd7};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 5'd0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};

    reset = 1'b1;
    start_a = 1'b1; abort_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b1; abort_b = 1'b0; ready_b = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_idle_a("rst");
      chk("rst.b_busy",  64'(busy_b),  64'd0);
      chk("rst.b_valid", 64'(valid_b), 64'd0);
      chk("rst.b_rr",    64'(rr_b),    64'd0);
    end
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    chk_idle_a("post_rst");
    chk("post_rst.b_busy", 64'(busy_b), 64'd0);

    // Narrow range table: one row per cycle, inputs applied and outputs checked together
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start_b = tbl[i].st;
      abort_b = tbl[i].ab;
      chk($sformatf("b[%0d].busy", i),  64'(busy_b),  64'(tbl[i].e_busy));
      chk($sformatf("b[%0d].stall", i), 64'(stall_b), 64'(tbl[i].e_busy));
      chk($sformatf("b[%0d].done", i),  64'(done_b),  64'(tbl[i].e_done));
      chk($sformatf("b[%0d].valid", i), 64'(valid_b), 64'(tbl[i].e_valid));
      chk($sformatf("b[%0d].rr", i),    64'(rr_b),    64'(tbl[i].e_rr));
      if (tbl[i].e_valid) begin
        chk($sformatf("b[%0d].idx", i),  64'(idx_b),  64'(tbl[i].e_idx));
        chk($sformatf("b[%0d].data", i), 64'(data_b), 64'(exp_data(int'(tbl[i].e_idx))));
      end else if (!tbl[i].e_busy) begin
        chk($sformatf("b[%0d].idx0", i),  64'(idx_b),  64'd0);
        chk($sformatf("b[%0d].data0", i), 64'(data_b), 64'd0);
      end
    end
    start_b = 1'b0; abort_b = 1'b0;

    dump_a(1'b0, 1'b0, 1'b1);   // full dump, then start in DONE / first IDLE
    dump_a(1'b1, 1'b0, 1'b0);   // 0,0,1 backpressure
    dump_a(1'b0, 1'b1, 1'b0);   // start pulses while busy
    kill_run(1'b0);
    dump_a(1'b0, 1'b0, 1'b0);
    kill_run(1'b1);
    dump_a(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
